spi_dac_transmitter: RTL and testbench

SPI master that serializes 12-bit samples into 16-bit frames for an external serial DAC (DAC121S101-class) on the output side of the FIR/IIR filter chain. It mirrors the ADC-side SPI receiver: same 100 MHz system clock, same sclk-idle-high convention, and the same active-low `ss`. It accepts one sample per valid/ready handshake and generates `sclk`, `ss` and `mosi` entirely in the `clk` domain. It flags samples offered while a frame is in flight.

---
 rtl/spi_dac_transmitter.sv | 157 +++++++++++++++
 tb/tb_spi_dac_transmitter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_transmitter.sv
// rtl/spi_dac_transmitter.sv - SPI master serializing filtered samples into DAC frames
module spi_dac_transmitter #(
   parameter int CLK_DIVIDER = 50,
   parameter int DATA_WIDTH  = 12,
   parameter int FRAME_BITS  = 16,
   parameter logic [FRAME_BITS-DATA_WIDTH-1:0] CTRL_WORD = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  ready,
   output logic                  sclk,
   output logic                  ss,
   output logic                  mosi,
   output logic                  done,
   output logic                  overrun
);

   localparam int CNT_W = $clog2(CLK_DIVIDER) + 1;
   localparam int BIT_W = $clog2(FRAME_BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDER - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_TRAIL,
      S_GAP
   } state_t;

   state_t                  state_q, state_n;
   logic [CNT_W-1:0]        cnt_q, cnt_n;
   logic [BIT_W-1:0]        bit_q, bit_n;
   // Holds the bits still to be sent after the one currently on mosi.
   logic [FRAME_BITS-2:0]   shreg_q, shreg_n;
   logic                    sclk_q, sclk_n;
   logic                    ss_q, ss_n;
   logic                    mosi_q, mosi_n;
   logic                    done_q, done_n;

   logic [FRAME_BITS-1:0]   frame_in;
   logic                    accept;
   logic                    cnt_end;

   assign frame_in = {CTRL_WORD, data_in};
   assign accept   = data_valid & (state_q == S_IDLE);
   assign cnt_end  = (cnt_q == CNT_LAST);

   // State and output registers; every SPI pin comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b1;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
         sclk_q  <= sclk_n;
         ss_q    <= ss_n;
         mosi_q  <= mosi_n;
         done_q  <= done_n;
      end
   end

   // Frame sequencing: half-period counter paces LEAD, SHIFT phases, TRAIL and GAP.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_end ? '0 : cnt_q + 1'b1;
      bit_n   = bit_q;
      shreg_n = shreg_q;
      sclk_n  = sclk_q;
      ss_n    = ss_q;
      mosi_n  = mosi_q;
      done_n  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_n = '0;
            if (accept) begin
               state_n = S_LEAD;
               bit_n   = '0;
               shreg_n = frame_in[FRAME_BITS-2:0];
               mosi_n  = frame_in[FRAME_BITS-1];
               ss_n    = 1'b0;
               sclk_n  = 1'b1;
            end
         end
         S_LEAD: begin
            if (cnt_end) begin
               state_n = S_SHIFT;
               cnt_n   = '0;
               sclk_n  = 1'b0;
            end
         end
         S_SHIFT: begin
            if (cnt_end) begin
               if (!sclk_q) begin
                  // Rising edge: present the next bit, or finish after the last one.
                  sclk_n = 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_n = S_TRAIL;
                     cnt_n   = '0;
                     mosi_n  = 1'b0;
                  end else begin
                     mosi_n  = shreg_q[FRAME_BITS-2];
                     shreg_n = {shreg_q[FRAME_BITS-3:0], 1'b0};
                  end
               end else begin
                  // Falling edge: the DAC samples the bit already on mosi.
                  sclk_n = 1'b0;
                  bit_n  = bit_q + 1'b1;
               end
            end
         end
         S_TRAIL: begin
            if (cnt_end) begin
               state_n = S_GAP;
               cnt_n   = '0;
               ss_n    = 1'b1;
               done_n  = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_end) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
            bit_n   = '0;
            shreg_n = '0;
            sclk_n  = 1'b1;
            ss_n    = 1'b1;
            mosi_n  = 1'b0;
         end
      endcase
   end

   assign ready   = (state_q == S_IDLE);
   assign overrun = data_valid & ~ready & ~rst;
   assign sclk    = sclk_q;
   assign ss      = ss_q;
   assign mosi    = mosi_q;
   assign done    = done_q;

endmodule

// File: tb/tb_spi_dac_transmitter.sv
// tb/tb_spi_dac_transmitter.sv - scoreboard bench for spi_dac_transmitter
module tb_spi_dac_transmitter;

   localparam int H = 4;

   logic        clk;
   logic        rst;
   logic [11:0] data_in;
   logic        data_valid;
   logic [1:0]  ready, sclk, ss, mosi, done, overrun;

   int tests_run;
   int tests_failed;
   int cyc;

   logic [15:0] exp_a[$];
   logic [15:0] got_a[$];
   logic [15:0] exp_b[$];
   logic [15:0] got_b[$];

   logic [15:0] cap[2];
   int          nbits[2];
   int          done_cnt[2];
   int          ovr_cnt[2];
   int          acc_cnt[2];
   int          viol[2];
   int          since_fall[2];
   int          since_mchg[2];
   logic        prev_sclk[2];
   logic        prev_mosi[2];

   spi_dac_transmitter #(.CLK_DIVIDER(H), .DATA_WIDTH(12), .FRAME_BITS(16), .CTRL_WORD(4'b0000)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .ready(ready[0]),
      .sclk(sclk[0]), .ss(ss[0]), .mosi(mosi[0]), .done(done[0]), .overrun(overrun[0])
   );

   spi_dac_transmitter #(.CLK_DIVIDER(H), .DATA_WIDTH(12), .FRAME_BITS(16), .CTRL_WORD(4'b0011)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .ready(ready[1]),
      .sclk(sclk[1]), .ss(ss[1]), .mosi(mosi[1]), .done(done[1]), .overrun(overrun[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pushes expected frames on acceptance, captures mosi on sclk falls, checks timing.
   always @(negedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            nbits[i] = 0;
            cap[i] = 16'h0;
            if (i == 0) exp_a.delete(); else exp_b.delete();
            prev_sclk[i] = 1'b1;
            prev_mosi[i] = 1'b0;
            since_fall[i] = 1000;
            since_mchg[i] = 1000;
         end else begin
            if (ready[i] && data_valid) begin
               acc_cnt[i]++;
               if (i == 0) exp_a.push_back({4'b0000, data_in});
               else        exp_b.push_back({4'b0011, data_in});
            end
            if (overrun[i]) ovr_cnt[i]++;
            if (ss[i] && !sclk[i]) viol[i]++;
            if (since_fall[i] < 1000) since_fall[i]++;
            if (since_mchg[i] < 1000) since_mchg[i]++;
            if (mosi[i] !== prev_mosi[i]) begin
               if (since_fall[i] < H) viol[i]++;
               since_mchg[i] = 0;
            end
            if (prev_sclk[i] && !sclk[i]) begin
               if (since_mchg[i] < H) viol[i]++;
               since_fall[i] = 0;
               if (!ss[i]) begin
                  cap[i] = {cap[i][14:0], mosi[i]};
                  nbits[i]++;
               end
            end
            if (done[i]) begin
               done_cnt[i]++;
               if (i == 0) got_a.push_back(cap[i]); else got_b.push_back(cap[i]);
               cap[i] = 16'h0;
               nbits[i] = 0;
            end
            prev_sclk[i] = sclk[i];
            prev_mosi[i] = mosi[i];
         end
      end
   end

   task automatic send(input logic [11:0] d);
      @(negedge clk);
      data_in = d;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (140) @(negedge clk);
   endtask

   task automatic pop_frame(input int which, output logic [15:0] got, output logic [15:0] expv, output bit ok);
      got = 16'h0;
      expv = 16'h0;
      ok = 1'b0;
      if (which == 0) begin
         if (got_a.size() > 0 && exp_a.size() > 0) begin
            got = got_a.pop_front(); expv = exp_a.pop_front(); ok = 1'b1;
         end
      end else begin
         if (got_b.size() > 0 && exp_b.size() > 0) begin
            got = got_b.pop_front(); expv = exp_b.pop_front(); ok = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      data_valid = 1'b1;
      data_in = 12'hFFF;
      repeat (3) @(negedge clk);
      #2;
      tests_run++; if (ready !== 2'b11) begin tests_failed++; $display("FAIL reset_ready: got %b expected 11", ready); end
      tests_run++; if (ss !== 2'b11) begin tests_failed++; $display("FAIL reset_ss: got %b expected 11", ss); end
      tests_run++; if (sclk !== 2'b11) begin tests_failed++; $display("FAIL reset_sclk: got %b expected 11", sclk); end
      tests_run++; if (mosi !== 2'b00) begin tests_failed++; $display("FAIL reset_mosi: got %b expected 00", mosi); end
      tests_run++; if (done !== 2'b00) begin tests_failed++; $display("FAIL reset_done: got %b expected 00", done); end
      tests_run++; if (overrun !== 2'b00) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 00", overrun); end
      @(negedge clk);
      data_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (acc_cnt[0] !== 0) begin tests_failed++; $display("FAIL reset_no_accept: got %0d expected 0", acc_cnt[0]); end
   endtask

   task automatic test_single_frame;
      int ss_low, done_at, done_n, rdy_at;
      logic rdy1, ss1;
      logic [15:0] g, e;
      bit ok;
      ss_low = 0; done_at = 0; done_n = 0; rdy_at = 0; rdy1 = 1'b1; ss1 = 1'b1;
      @(negedge clk);
      data_in = 12'hA5C;
      data_valid = 1'b1;
      for (int n = 1; n <= 140; n++) begin
         @(negedge clk);
         if (n == 1) begin
            data_valid = 1'b0;
            rdy1 = ready[0];
            ss1 = ss[0];
            data_in = 12'h3C3;
         end
         if (!ss[0]) ss_low++;
         if (done[0]) begin done_n++; done_at = n; end
         if (ready[0] && rdy_at == 0) rdy_at = n;
      end
      tests_run++; if (rdy1 !== 1'b0) begin tests_failed++; $display("FAIL single_ready_low: got %b expected 0", rdy1); end
      tests_run++; if (ss1 !== 1'b0) begin tests_failed++; $display("FAIL single_ss_t1: got %b expected 0", ss1); end
      tests_run++; if (ss_low != 132) begin tests_failed++; $display("FAIL single_ss_low_cycles: got %0d expected 132", ss_low); end
      tests_run++; if (done_at != 133) begin tests_failed++; $display("FAIL single_done_cycle: got %0d expected 133", done_at); end
      tests_run++; if (done_n != 1) begin tests_failed++; $display("FAIL single_done_count: got %0d expected 1", done_n); end
      tests_run++; if (rdy_at != 137) begin tests_failed++; $display("FAIL single_ready_return: got %0d expected 137", rdy_at); end
      pop_frame(0, g, e, ok);
      tests_run++; if (!ok || g !== 16'h0A5C || e !== 16'h0A5C) begin tests_failed++; $display("FAIL single_frame_a: got %h expected 0a5c", g); end
      pop_frame(1, g, e, ok);
      tests_run++; if (!ok || g !== 16'h3A5C || e !== 16'h3A5C) begin tests_failed++; $display("FAIL single_frame_b: got %h expected 3a5c", g); end
   endtask

   task automatic test_ctrl_extremes;
      logic [15:0] g, e;
      bit ok;
      send(12'hFFF);
      send(12'h000);
      pop_frame(1, g, e, ok);
      tests_run++; if (!ok || g !== 16'h3FFF || g !== e) begin tests_failed++; $display("FAIL ctrl_fff_b: got %h expected 3fff", g); end
      pop_frame(1, g, e, ok);
      tests_run++; if (!ok || g !== 16'h3000 || g !== e) begin tests_failed++; $display("FAIL ctrl_000_b: got %h expected 3000", g); end
      pop_frame(0, g, e, ok);
      tests_run++; if (!ok || g !== 16'h0FFF || g !== e) begin tests_failed++; $display("FAIL ctrl_fff_a: got %h expected 0fff", g); end
      pop_frame(0, g, e, ok);
      tests_run++; if (!ok || g !== 16'h0000 || g !== e) begin tests_failed++; $display("FAIL ctrl_000_a: got %h expected 0000", g); end
   endtask

   task automatic test_back_to_back;
      int acc[3];
      int k, run, runs, bad_runs;
      bit upd, seen_low;
      logic [15:0] g, e;
      bit ok;
      k = 0; run = 0; runs = 0; bad_runs = 0; upd = 0; seen_low = 0;
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      @(negedge clk);
      data_in = 12'h001;
      data_valid = 1'b1;
      for (int n = 0; n < 470; n++) begin
         if (n > 0) @(negedge clk);
         if (ss[0]) run++;
         else begin
            if (seen_low && run > 0) begin
               runs++;
               if (run != H + 1) bad_runs++;
            end
            run = 0;
            seen_low = 1;
         end
         if (upd) begin data_in = 12'(k + 1); upd = 0; end
         if (k == 3 && !ready[0]) data_valid = 1'b0;
         if (k < 3 && ready[0]) begin acc[k] = cyc; k++; upd = 1; end
      end
      data_valid = 1'b0;
      tests_run++; if (k != 3) begin tests_failed++; $display("FAIL b2b_accepts: got %0d expected 3", k); end
      tests_run++; if (acc[1] - acc[0] != 137) begin tests_failed++; $display("FAIL b2b_spacing_1: got %0d expected 137", acc[1] - acc[0]); end
      tests_run++; if (acc[2] - acc[1] != 137) begin tests_failed++; $display("FAIL b2b_spacing_2: got %0d expected 137", acc[2] - acc[1]); end
      tests_run++; if (runs != 2 || bad_runs != 0) begin tests_failed++; $display("FAIL b2b_ss_gap: got %0d gaps with %0d wrong length expected 2 gaps of %0d", runs, bad_runs, H + 1); end
      for (int f = 1; f <= 3; f++) begin
         pop_frame(0, g, e, ok);
         tests_run++; if (!ok || g !== 16'(f) || g !== e) begin tests_failed++; $display("FAIL b2b_frame_%0d: got %h expected %h", f, g, 16'(f)); end
      end
      exp_b.delete();
      got_b.delete();
   endtask

   task automatic test_overrun;
      int ovr0;
      logic ov_on, ov_off;
      logic [15:0] g, e;
      bit ok;
      ovr0 = ovr_cnt[0];
      ov_on = 1'b0; ov_off = 1'b1;
      @(negedge clk);
      data_in = 12'h456;
      data_valid = 1'b1;
      for (int n = 1; n <= 140; n++) begin
         @(negedge clk);
         if (n == 1) data_valid = 1'b0;
         if (n == 50) begin
            data_in = 12'h123; data_valid = 1'b1;
            #1 ov_on = overrun[0] & overrun[1];
         end
         if (n == 51) begin
            data_valid = 1'b0;
            #1 ov_off = overrun[0] | overrun[1];
         end
         if (n == 80) data_in = 12'hFFF;
      end
      tests_run++; if (ov_on !== 1'b1) begin tests_failed++; $display("FAIL overrun_pulse: got %b expected 1", ov_on); end
      tests_run++; if (ov_off !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b expected 0", ov_off); end
      tests_run++; if (ovr_cnt[0] - ovr0 != 1) begin tests_failed++; $display("FAIL overrun_count: got %0d expected 1", ovr_cnt[0] - ovr0); end
      pop_frame(0, g, e, ok);
      tests_run++; if (!ok || g !== 16'h0456 || g !== e) begin tests_failed++; $display("FAIL overrun_frame_a: got %h expected 0456", g); end
      pop_frame(1, g, e, ok);
      tests_run++; if (!ok || g !== 16'h3456 || g !== e) begin tests_failed++; $display("FAIL overrun_frame_b: got %h expected 3456", g); end
   endtask

   task automatic test_reset_midframe;
      int done0;
      logic [15:0] g, e;
      bit ok;
      done0 = done_cnt[0];
      @(negedge clk);
      data_in = 12'h777;
      data_valid = 1'b1;
      for (int n = 1; n <= 71; n++) begin
         @(negedge clk);
         if (n == 1) data_valid = 1'b0;
         if (n == 70) begin
            tests_run++; if (ss !== 2'b00) begin tests_failed++; $display("FAIL rstmid_in_frame: got ss %b expected 00", ss); end
            rst = 1'b1;
         end
         if (n == 71) begin
            tests_run++; if (ss !== 2'b11) begin tests_failed++; $display("FAIL rstmid_ss: got %b expected 11", ss); end
            tests_run++; if (sclk !== 2'b11) begin tests_failed++; $display("FAIL rstmid_sclk: got %b expected 11", sclk); end
            tests_run++; if (mosi !== 2'b00) begin tests_failed++; $display("FAIL rstmid_mosi: got %b expected 00", mosi); end
            tests_run++; if (ready !== 2'b11) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 11", ready); end
            rst = 1'b0;
         end
      end
      repeat (140) @(negedge clk);
      tests_run++; if (done_cnt[0] != done0 || got_a.size() != 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", done_cnt[0] - done0); end
      send(12'h5A5);
      pop_frame(0, g, e, ok);
      tests_run++; if (!ok || g !== 16'h05A5 || g !== e) begin tests_failed++; $display("FAIL rstmid_next_frame_a: got %h expected 05a5", g); end
      pop_frame(1, g, e, ok);
      tests_run++; if (!ok || g !== 16'h35A5 || g !== e) begin tests_failed++; $display("FAIL rstmid_next_frame_b: got %h expected 35a5", g); end
   endtask

   task automatic test_timing_stream;
      int acc0[2], done0[2];
      int budget, bad;
      logic [15:0] g, e;
      bit ok;
      for (int i = 0; i < 2; i++) begin
         viol[i] = 0; acc0[i] = acc_cnt[i]; done0[i] = done_cnt[i];
      end
      exp_a.delete(); got_a.delete(); exp_b.delete(); got_b.delete();
      budget = 0;
      while (acc_cnt[0] - acc0[0] < 200 && budget < 60000) begin
         @(negedge clk);
         budget++;
         data_in = 12'($urandom);
         data_valid = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      data_valid = 1'b0;
      tests_run++; if (acc_cnt[0] - acc0[0] != 200) begin tests_failed++; $display("FAIL stream_budget: got %0d accepts expected 200", acc_cnt[0] - acc0[0]); end
      repeat (150) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests_run++; if (viol[i] != 0) begin tests_failed++; $display("FAIL stream_timing_%0d: got %0d violations expected 0", i, viol[i]); end
         tests_run++; if (done_cnt[i] - done0[i] != acc_cnt[i] - acc0[i]) begin tests_failed++; $display("FAIL stream_done_count_%0d: got %0d expected %0d", i, done_cnt[i] - done0[i], acc_cnt[i] - acc0[i]); end
      end
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         for (int f = 0; f < 200; f++) begin
            pop_frame(i, g, e, ok);
            if (!ok || g !== e) begin
               bad++;
               if (bad < 10) $display("FAIL stream_frame_%0d_%0d: got %h expected %h", i, f, g, e);
            end
         end
      end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stream_frames: got %0d bad frames expected 0", bad); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      data_in = 12'h000;
      data_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cap[i] = 16'h0; nbits[i] = 0; done_cnt[i] = 0; ovr_cnt[i] = 0; acc_cnt[i] = 0; viol[i] = 0;
         since_fall[i] = 1000; since_mchg[i] = 1000; prev_sclk[i] = 1'b1; prev_mosi[i] = 1'b0;
      end
      test_reset();
      test_single_frame();
      test_ctrl_extremes();
      test_back_to_back();
      test_overrun();
      test_reset_midframe();
      test_timing_stream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
